micro_ucr_nonce_search: RTL and testbench

// Nonce-search controller sitting directly upstream of the micro_ucr hash unit.
// - Latches a 96-bit block and an 8-bit target on start.
// - Issues one nonce per cycle to the hash unit and checks each returned 24-bit hash.
// - Stops at the first nonce whose hash satisfies the target and reports it.
// - Reports not-found if the nonce space is exhausted first.

---
 rtl/micro_ucr_pkg.sv | 12 +
 rtl/ucr_tag_pipe.sv | 40 ++++
 rtl/micro_ucr_nonce_search.sv | 124 ++++++++++++
 tb/tb_micro_ucr_nonce_search.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_ucr_pkg.sv
// micro_ucr_pkg: shared widths, FSM states and the hash/target hit rule for the nonce search
package micro_ucr_pkg;
  localparam int BLOCK_W = 96;
  localparam int NONCE_W = 32;
  localparam int HASH_W  = 24;
  localparam int BYTE_W  = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  // both upper hash bytes must be strictly below the target, so target 0 never hits
  function automatic logic ucr_hit(input logic [HASH_W-1:0] hash, input logic [BYTE_W-1:0] tgt);
    return (hash[23:16] < tgt) && (hash[15:8] < tgt);
  endfunction
endpackage

// File: rtl/ucr_tag_pipe.sv
// ucr_tag_pipe: DEPTH-stage {valid,tag} shift register with flush; DEPTH=0 is a pass-through
module ucr_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_tag,
  output logic         out_valid,
  output logic [W-1:0] out_tag
);
  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, reset, flush};
    assign out_valid = in_valid;
    assign out_tag   = in_tag;
  end else begin : g_shift
    logic [DEPTH-1:0]   v_q, v_d;
    logic [DEPTH*W-1:0] t_q, t_d;
    // shift one stage per cycle; a flush only kills the valid bits, stale tags are harmless
    always_comb begin
      v_d = flush ? '0 : DEPTH'({v_q, in_valid});
      t_d = (DEPTH*W)'({t_q, in_tag});
    end
    // pipe registers
    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= '0;
        t_q <= '0;
      end else begin
        v_q <= v_d;
        t_q <= t_d;
      end
    end
    assign out_valid = v_q[DEPTH-1];
    assign out_tag   = t_q[DEPTH*W-1 -: W];
  end
endmodule

// File: rtl/micro_ucr_nonce_search.sv
// micro_ucr_nonce_search: issues nonces to the hash unit and reports the first hit; UCR_NONCE_SEARCH_CYCLES_EN adds cycles_out
module micro_ucr_nonce_search
  import micro_ucr_pkg::*;
#(
  parameter int                 HASH_LAT  = 2,
  parameter logic [NONCE_W-1:0] NONCE_MAX = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BLOCK_W-1:0] bloque_in,
  input  logic [BYTE_W-1:0]  target,
  input  logic [HASH_W-1:0]  hash_in,
  output logic [BLOCK_W-1:0] bloque_bytes,
  output logic [NONCE_W-1:0] nonce,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] nonce_found,
  output logic [HASH_W-1:0]  hash_found
`ifdef UCR_NONCE_SEARCH_CYCLES_EN
  ,
  output logic [31:0]        cycles_out
`endif
);
  state_e               state_q, state_d;
  logic [BLOCK_W-1:0]   bloque_q, bloque_d;
  logic [BYTE_W-1:0]    target_q, target_d;
  logic [NONCE_W-1:0]   nonce_q, nonce_d;
  logic                 busy_q, busy_d, done_q, done_d, found_q, found_d;
  logic [NONCE_W-1:0]   nf_q, nf_d;
  logic [HASH_W-1:0]    hf_q, hf_d;
  logic                 tag_valid, hit, last;
  logic [NONCE_W-1:0]   tag;
  ucr_tag_pipe #(.DEPTH(HASH_LAT), .W(NONCE_W)) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .flush    (hit),
    .in_valid (state_q == RUN),
    .in_tag   (nonce_q),
    .out_valid(tag_valid),
    .out_tag  (tag)
  );
  assign hit  = (state_q == RUN || state_q == DRAIN) && tag_valid && ucr_hit(hash_in, target_q);
  assign last = tag_valid && tag == NONCE_MAX;
  // next-state and result capture; a hit overrides both issuing and exhaustion
  always_comb begin
    state_d  = state_q;
    bloque_d = bloque_q;
    target_d = target_q;
    nonce_d  = nonce_q;
    found_d  = found_q;
    nf_d     = nf_q;
    hf_d     = hf_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = RUN;
        bloque_d = bloque_in;
        target_d = target;
        nonce_d  = '0;
        found_d  = 1'b0;
        nf_d     = '0;
        hf_d     = '0;
      end
      RUN: begin
        state_d = last ? DONE : nonce_q == NONCE_MAX ? DRAIN : RUN;
        nonce_d = nonce_q == NONCE_MAX ? nonce_q : nonce_q + NONCE_W'(1);
      end
      DRAIN: state_d = last ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
    if (hit) begin
      state_d = DONE;
      nonce_d = nonce_q;
      found_d = 1'b1;
      nf_d    = tag;
      hf_d    = hash_in;
    end
    busy_d = state_d == RUN || state_d == DRAIN;
    done_d = state_d == DONE;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bloque_q <= '0;
      target_q <= '0;
      nonce_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      nf_q     <= '0;
      hf_q     <= '0;
    end else begin
      state_q  <= state_d;
      bloque_q <= bloque_d;
      target_q <= target_d;
      nonce_q  <= nonce_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      nf_q     <= nf_d;
      hf_q     <= hf_d;
    end
  end
`ifdef UCR_NONCE_SEARCH_CYCLES_EN
  logic [31:0] cyc_q, cyc_d;
  // count RUN/DRAIN cycles of the current search, saturating
  always_comb cyc_d = (state_q == IDLE && start) ? '0 : (busy_q && ~&cyc_q) ? cyc_q + 32'd1 : cyc_q;
  // cycle counter register
  always_ff @(posedge clk) begin
    if (reset) cyc_q <= '0;
    else cyc_q <= cyc_d;
  end
  assign cycles_out = cyc_q;
`endif
  assign bloque_bytes = bloque_q;
  assign nonce        = nonce_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign found        = found_q;
  assign nonce_found  = nf_q;
  assign hash_found   = hf_q;
endmodule

// File: tb/tb_micro_ucr_nonce_search.sv
// tb_micro_ucr_nonce_search: three configurations of the search against a first-hit reference model
module tb_micro_ucr_nonce_search;
  logic        clk, reset;
  logic [2:0]  start;
  logic [95:0] bloque;
  logic [7:0]  target;
  logic [23:0] lut [256];
  logic [95:0] bb [3];
  logic [31:0] nv [3], nf [3];
  logic        bz [3], dn [3], fd [3];
  logic [23:0] hf [3];
`ifdef UCR_NONCE_SEARCH_CYCLES_EN
  logic [31:0] cy [3];
`endif
  int nmax [3] = '{255, 15, 240};
  int hlat [3] = '{2, 2, 0};
  int n_cmp, n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int          L  = g == 2 ? 0 : 2;
    localparam logic [31:0] NM = g == 0 ? 32'd255 : g == 1 ? 32'd15 : 32'd240;
    logic [23:0] d1, d2, h;
    always @(posedge clk) begin
      d1 <= lut[nv[g][7:0]];
      d2 <= d1;
    end
    assign h = L == 0 ? lut[nv[g][7:0]] : d2;
    micro_ucr_nonce_search #(.HASH_LAT(L), .NONCE_MAX(NM)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start[g]),
      .bloque_in   (bloque),
      .target      (target),
      .hash_in     (h),
      .bloque_bytes(bb[g]),
      .nonce       (nv[g]),
      .busy        (bz[g]),
      .done        (dn[g]),
      .found       (fd[g]),
      .nonce_found (nf[g]),
      .hash_found  (hf[g])
`ifdef UCR_NONCE_SEARCH_CYCLES_EN
      ,
      .cycles_out  (cy[g])
`endif
    );
  end

  function automatic int model(input int sel, input logic [7:0] t);
    for (int n = 0; n <= nmax[sel]; n++)
      if (lut[n][23:16] < t && lut[n][15:8] < t) return n;
    return -1;
  endfunction

  task automatic spec_lut();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      lut[i] = {~b, ~b, 8'h00};
    end
  endtask

  task automatic run_search(input int sel, input logic [7:0] t, input logic [95:0] blk, input int pulse_at,
                            output int lat, output logic [31:0] n0, output logic b0);
    @(negedge clk);
    target = t;
    bloque = blk;
    start[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[sel] = 1'b0;
    lat = -1;
    n0 = nv[sel];
    b0 = bz[sel];
    for (int k = 0; k < 3000; k++) begin
      if (dn[sel]) begin
        lat = k;
        break;
      end
      start[sel] = (k == pulse_at);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = '0;
    target = '0;
    bloque = '0;
    spec_lut();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({bb[i], nv[i], bz[i], dn[i], fd[i], nf[i], hf[i]} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs[%0d]: got nonce=%h busy=%b done=%b found=%b nf=%h hf=%h want all 0", i, nv[i], bz[i], dn[i], fd[i], nf[i], hf[i]);
      end
`ifdef UCR_NONCE_SEARCH_CYCLES_EN
      n_cmp++;
      if (cy[i] !== 32'd0) begin n_bad++; $display("FAIL reset_cycles[%0d]: got %0d want 0", i, cy[i]); end
`endif
    end
    reset = 1'b0;
  endtask

  task automatic test_first_hit();
    int lat;
    logic [31:0] n0;
    logic b0;
    logic [95:0] blk;
    spec_lut();
    blk = {$urandom, $urandom, $urandom};
    run_search(0, 8'h10, blk, -1, lat, n0, b0);
    n_cmp += 7;
    if (lat !== 243) begin n_bad++; $display("FAIL hit_latency: got %0d want 243", lat); end
    if (fd[0] !== 1'b1) begin n_bad++; $display("FAIL hit_found: got %b want 1", fd[0]); end
    if (nf[0] !== 32'hF0) begin n_bad++; $display("FAIL hit_nonce: got %h want f0", nf[0]); end
    if (hf[0] !== 24'h0F0F00) begin n_bad++; $display("FAIL hit_hash: got %h want 0f0f00", hf[0]); end
    if (bb[0] !== blk) begin n_bad++; $display("FAIL hit_block: got %h want %h", bb[0], blk); end
    if (n0 !== 32'd0 || b0 !== 1'b1) begin n_bad++; $display("FAIL hit_first_cycle: got nonce=%h busy=%b want 0/1", n0, b0); end
`ifdef UCR_NONCE_SEARCH_CYCLES_EN
    if (cy[0] !== 32'd243) begin n_bad++; $display("FAIL hit_cycles: got %0d want 243", cy[0]); end
`else
    n_cmp--;
`endif
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({dn[0], bz[0], fd[0], nf[0]} !== {1'b0, 1'b0, 1'b1, 32'hF0}) begin
      n_bad++;
      $display("FAIL hit_hold: got done=%b busy=%b found=%b nf=%h want 0/0/1/f0", dn[0], bz[0], fd[0], nf[0]);
    end
  endtask

  task automatic test_exhaust();
    int lat;
    logic [31:0] n0;
    logic b0;
    spec_lut();
    run_search(1, 8'h00, 96'h1, -1, lat, n0, b0);
    n_cmp += 3;
    if (lat !== 18) begin n_bad++; $display("FAIL exhaust_latency: got %0d want 18", lat); end
    if ({fd[1], nf[1], hf[1]} !== '0) begin n_bad++; $display("FAIL exhaust_result: got found=%b nf=%h hf=%h want 0", fd[1], nf[1], hf[1]); end
    if (nv[1] !== 32'd15) begin n_bad++; $display("FAIL exhaust_nonce_hold: got %h want f", nv[1]); end
  endtask

  task automatic test_lat0();
    int lat, n;
    logic [31:0] n0;
    logic b0;
    spec_lut();
    n = model(2, 8'hFF);
    run_search(2, 8'hFF, 96'h2, -1, lat, n0, b0);
    n_cmp += 2;
    if (lat !== n + 1) begin n_bad++; $display("FAIL lat0_latency: got %0d want %0d", lat, n + 1); end
    if (fd[2] !== 1'b1 || nf[2] !== 32'(n) || hf[2] !== lut[n]) begin
      n_bad++;
      $display("FAIL lat0_result: got found=%b nf=%h hf=%h want 1/%h/%h", fd[2], nf[2], hf[2], n, lut[n]);
    end
    lut[0] = 24'h000000;
    run_search(2, 8'hFF, 96'h3, -1, lat, n0, b0);
    n_cmp += 2;
    if (lat !== 1) begin n_bad++; $display("FAIL lat0_zero_latency: got %0d want 1", lat); end
    if (fd[2] !== 1'b1 || nf[2] !== 32'd0) begin n_bad++; $display("FAIL lat0_zero_result: got found=%b nf=%h want 1/0", fd[2], nf[2]); end
  endtask

  task automatic test_reset_mid();
    int lat, seen;
    logic [31:0] n0;
    logic b0;
    spec_lut();
    @(negedge clk);
    target = 8'h00;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({bb[0], nv[0], bz[0], dn[0], fd[0], nf[0], hf[0]} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got nonce=%h busy=%b done=%b want all 0", nv[0], bz[0], dn[0]);
    end
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      seen += int'(dn[0]) + int'(bz[0]);
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL midreset_quiet: got %0d done/busy cycles want 0", seen); end
    run_search(0, 8'h10, 96'h4, -1, lat, n0, b0);
    n_cmp += 2;
    if (n0 !== 32'd0) begin n_bad++; $display("FAIL midreset_restart_nonce: got %h want 0", n0); end
    if (lat !== 243 || nf[0] !== 32'hF0) begin n_bad++; $display("FAIL midreset_restart_result: got lat=%0d nf=%h want 243/f0", lat, nf[0]); end
  endtask

  task automatic test_hit_on_last();
    int lat;
    logic [31:0] n0;
    logic b0;
    spec_lut();
    run_search(2, 8'h10, 96'h5, 7, lat, n0, b0);
    n_cmp += 2;
    if (lat !== 241) begin n_bad++; $display("FAIL last_latency: got %0d want 241", lat); end
    if (fd[2] !== 1'b1 || nf[2] !== 32'hF0 || hf[2] !== 24'h0F0F00) begin
      n_bad++;
      $display("FAIL last_result: got found=%b nf=%h hf=%h want 1/f0/0f0f00", fd[2], nf[2], hf[2]);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    spec_lut();
    @(negedge clk);
    target = 8'hFF;
    start[1] = 1'b1;
    lat = -1;
    for (int k = 0; k < 100 && lat < 0; k++) begin
      @(negedge clk);
      if (dn[1]) lat = k;
    end
    n_cmp++;
    if (lat < 0 || fd[1] !== 1'b1 || nf[1] !== 32'd1) begin n_bad++; $display("FAIL b2b_first: got lat=%0d found=%b nf=%h want 1/1", lat, fd[1], nf[1]); end
    target = 8'h00;
    @(negedge clk);
    n_cmp++;
    if (bz[1] !== 1'b0 || dn[1] !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got busy=%b done=%b want 0/0", bz[1], dn[1]); end
    @(negedge clk);
    start[1] = 1'b0;
    n_cmp++;
    if ({bz[1], nv[1], fd[1], nf[1]} !== {1'b1, 32'd0, 1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL b2b_restart: got busy=%b nonce=%h found=%b nf=%h want 1/0/0/0", bz[1], nv[1], fd[1], nf[1]);
    end
    lat = -1;
    for (int k = 1; k < 100 && lat < 0; k++) begin
      @(negedge clk);
      if (dn[1]) lat = k;
    end
    n_cmp++;
    if (lat !== 18 || fd[1] !== 1'b0) begin n_bad++; $display("FAIL b2b_second: got lat=%0d found=%b want 18/0", lat, fd[1]); end
  endtask

  task automatic test_random();
    int lat, n, sel, exp_lat;
    logic [31:0] n0;
    logic b0;
    logic [7:0] t;
    logic [95:0] blk;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 256; i++) lut[i] = 24'($urandom);
      t = (it % 5 == 4) ? 8'h00 : 8'($urandom_range(1, 40));
      sel = $urandom_range(0, 2);
      blk = {$urandom, $urandom, $urandom};
      n = model(sel, t);
      exp_lat = (n < 0 ? nmax[sel] : n) + hlat[sel] + 1;
      run_search(sel, t, blk, -1, lat, n0, b0);
      n_cmp += 3;
      if (lat !== exp_lat) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, lat, exp_lat); end
      if (fd[sel] !== (n >= 0) || nf[sel] !== (n >= 0 ? 32'(n) : 32'd0) || hf[sel] !== (n >= 0 ? lut[n] : 24'd0)) begin
        n_bad++;
        $display("FAIL rand_result[%0d]: got found=%b nf=%h hf=%h want nonce %0d", it, fd[sel], nf[sel], hf[sel], n);
      end
      if (bb[sel] !== blk) begin n_bad++; $display("FAIL rand_block[%0d]: got %h want %h", it, bb[sel], blk); end
`ifdef UCR_NONCE_SEARCH_CYCLES_EN
      n_cmp++;
      if (cy[sel] !== 32'(exp_lat)) begin n_bad++; $display("FAIL rand_cycles[%0d]: got %0d want %0d", it, cy[sel], exp_lat); end
`endif
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_first_hit();
    test_exhaust();
    test_lat0();
    test_reset_mid();
    test_hit_on_last();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
